// File: rtl/rsa_seq_pkg.sv
// Shared types and constants for the RSA job sequencer and its key cache.
package rsa_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INV_PULSE,
      S_INV_GUARD,
      S_INV_WAIT,
      S_EXP_PULSE,
      S_EXP_GUARD,
      S_EXP_WAIT,
      S_RESULT
   } seq_state_t;

   localparam int DEFAULT_WIDTH          = 128;
   localparam int DEFAULT_TIMEOUT_CYCLES = 2000000;

   // Latched job word: p, q, direction bit and a 2*width message.
   function automatic int job_bits(input int width);
      return 4 * width + 1;
   endfunction

   localparam int JOB_FIELDS = job_bits(DEFAULT_WIDTH);

endpackage

// File: rtl/rsa_key_cache.sv
// Remembers the last key pair whose inverter run completed, so repeat keys skip it.
module rsa_key_cache
   import rsa_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_load_p,
   input  logic [WIDTH-1:0] i_load_q,
   input  logic [WIDTH-1:0] i_cmp_p,
   input  logic [WIDTH-1:0] i_cmp_q,
   output logic             o_hit
);

   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_q;
   logic             r_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p     <= '0;
         r_q     <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_p     <= i_load_p;
         r_q     <= i_load_q;
         r_valid <= 1'b1;
      end
   end

   assign o_hit = r_valid && (i_cmp_p == r_p) && (i_cmp_q == r_q);

endmodule

// File: rtl/rsa_job_sequencer.sv
// Job front end for the RSA control datapath: inverter run, mod-exp run, result handoff.
module rsa_job_sequencer
   import rsa_seq_pkg::*;
#(
   parameter int WIDTH          = DEFAULT_WIDTH,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [WIDTH-1:0]   job_p,
   input  logic [WIDTH-1:0]   job_q,
   input  logic               job_encrypt_decrypt,
   input  logic [2*WIDTH-1:0] job_msg,
   output logic [WIDTH-1:0]   ctl_p,
   output logic [WIDTH-1:0]   ctl_q,
   output logic               ctl_encrypt_decrypt,
   output logic [2*WIDTH-1:0] ctl_msg_in,
   output logic               ctl_reset_inverter,
   output logic               ctl_reset_mod_exp,
   input  logic               ctl_inverter_finish,
   input  logic               ctl_mod_exp_finish,
   input  logic [2*WIDTH-1:0] ctl_msg_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_msg,
   output logic               res_error,
   output logic [15:0]        jobs_done
);

   localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam int                 JOB_W    = job_bits(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_t         r_state;
   seq_state_t         w_state_nxt;
   logic [JOB_W-1:0]   r_job;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_res_msg;
   logic               r_res_error;
   logic [15:0]        r_jobs_done;

   logic w_accept;
   logic w_key_hit;
   logic w_key_load;
   logic w_key_clear;
   logic w_cnt_clr;
   logic w_cnt_expired;
   logic w_in_wait;
   logic w_res_ok;
   logic w_res_abort;
   logic w_handshake;

   assign w_accept      = job_valid && (r_state == S_IDLE);
   assign w_cnt_expired = (r_cnt == CNT_LAST);
   assign w_in_wait     = (r_state == S_INV_WAIT) || (r_state == S_EXP_WAIT);

   rsa_key_cache #(.WIDTH(WIDTH)) u_key_cache (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_key_load),
      .i_clear  (w_key_clear),
      .i_load_p (ctl_p),
      .i_load_q (ctl_q),
      .i_cmp_p  (job_p),
      .i_cmp_q  (job_q),
      .o_hit    (w_key_hit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Finish wins over timeout because it is tested first in each WAIT state.
   always_comb begin
      w_state_nxt = r_state;
      w_key_load  = 1'b0;
      w_key_clear = 1'b0;
      w_cnt_clr   = 1'b0;
      w_res_ok    = 1'b0;
      w_res_abort = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         S_IDLE:      if (job_valid) w_state_nxt = w_key_hit ? S_EXP_PULSE : S_INV_PULSE;
         S_INV_PULSE: w_state_nxt = S_INV_GUARD;
         S_INV_GUARD: begin
            w_state_nxt = S_INV_WAIT;
            w_cnt_clr   = 1'b1;
         end
         S_INV_WAIT: begin
            if (ctl_inverter_finish) begin
               w_key_load  = 1'b1;
               w_state_nxt = S_EXP_PULSE;
            end else if (w_cnt_expired) begin
               w_res_abort = 1'b1;
               w_key_clear = 1'b1;
               w_state_nxt = S_RESULT;
            end
         end
         S_EXP_PULSE: w_state_nxt = S_EXP_GUARD;
         S_EXP_GUARD: begin
            w_state_nxt = S_EXP_WAIT;
            w_cnt_clr   = 1'b1;
         end
         S_EXP_WAIT: begin
            if (ctl_mod_exp_finish) begin
               w_res_ok    = 1'b1;
               w_state_nxt = S_RESULT;
            end else if (w_cnt_expired) begin
               w_res_abort = 1'b1;
               w_key_clear = 1'b1;
               w_state_nxt = S_RESULT;
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               w_handshake = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_job       <= '0;
         r_cnt       <= '0;
         r_res_msg   <= '0;
         r_res_error <= 1'b0;
         r_jobs_done <= '0;
      end else begin
         if (w_accept) r_job <= {job_p, job_q, job_encrypt_decrypt, job_msg};
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_in_wait) r_cnt <= r_cnt + 1'b1;
         if (w_res_ok) begin
            r_res_msg   <= ctl_msg_out;
            r_res_error <= 1'b0;
         end else if (w_res_abort) begin
            r_res_msg   <= '0;
            r_res_error <= 1'b1;
         end
         if (w_handshake) r_jobs_done <= r_jobs_done + 16'd1;
      end
   end

   assign {ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in} = r_job;

   // Pulses and status are decodes of the state register, so they reset to 0 (job_ready to 1).
   assign ctl_reset_inverter = (r_state == S_INV_PULSE);
   assign ctl_reset_mod_exp  = (r_state == S_EXP_PULSE);
   assign job_ready          = (r_state == S_IDLE);
   assign res_valid          = (r_state == S_RESULT);
   assign res_msg            = r_res_msg;
   assign res_error          = r_res_error;
   assign jobs_done          = r_jobs_done;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Scoreboard bench for rsa_job_sequencer with a behavioural model of the control datapath.
module tb_rsa_job_sequencer;

   localparam int W  = 128;
   localparam int MW = 2 * W;
   localparam int TO = 100;

   localparam logic [W-1:0] P1 = 128'd8475698667747010771;
   localparam logic [W-1:0] Q1 = 128'd11297384090418420749;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          job_valid = 1'b0;
   logic          job_ready;
   logic [W-1:0]  job_p = '0;
   logic [W-1:0]  job_q = '0;
   logic          job_encrypt_decrypt = 1'b0;
   logic [MW-1:0] job_msg = '0;
   logic [W-1:0]  ctl_p;
   logic [W-1:0]  ctl_q;
   logic          ctl_encrypt_decrypt;
   logic [MW-1:0] ctl_msg_in;
   logic          ctl_reset_inverter;
   logic          ctl_reset_mod_exp;
   logic          ctl_inverter_finish = 1'b0;
   logic          ctl_mod_exp_finish = 1'b0;
   logic [MW-1:0] ctl_msg_out = '0;
   logic          res_valid;
   logic          res_ready = 1'b1;
   logic [MW-1:0] res_msg;
   logic          res_error;
   logic [15:0]   jobs_done;

   rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk                 (clk),
      .reset               (reset),
      .job_valid           (job_valid),
      .job_ready           (job_ready),
      .job_p               (job_p),
      .job_q               (job_q),
      .job_encrypt_decrypt (job_encrypt_decrypt),
      .job_msg             (job_msg),
      .ctl_p               (ctl_p),
      .ctl_q               (ctl_q),
      .ctl_encrypt_decrypt (ctl_encrypt_decrypt),
      .ctl_msg_in          (ctl_msg_in),
      .ctl_reset_inverter  (ctl_reset_inverter),
      .ctl_reset_mod_exp   (ctl_reset_mod_exp),
      .ctl_inverter_finish (ctl_inverter_finish),
      .ctl_mod_exp_finish  (ctl_mod_exp_finish),
      .ctl_msg_out         (ctl_msg_out),
      .res_valid           (res_valid),
      .res_ready           (res_ready),
      .res_msg             (res_msg),
      .res_error           (res_error),
      .jobs_done           (jobs_done)
   );

   always #5 clk = ~clk;

   // Control model: finish 20/50 cycles after the pulse, cleared by the pulse.
   logic model_en = 1'b1;
   int   inv_cnt  = 0;
   int   exp_cnt  = 0;
   always @(posedge clk) begin
      if (ctl_reset_inverter) begin
         ctl_inverter_finish <= 1'b0;
         inv_cnt             <= 20;
      end else if (inv_cnt > 0) begin
         inv_cnt <= inv_cnt - 1;
         if (inv_cnt == 1 && model_en) ctl_inverter_finish <= 1'b1;
      end
      if (ctl_reset_mod_exp) begin
         ctl_mod_exp_finish <= 1'b0;
         exp_cnt            <= 50;
      end else if (exp_cnt > 0) begin
         exp_cnt <= exp_cnt - 1;
         if (exp_cnt == 1 && model_en) begin
            ctl_mod_exp_finish <= 1'b1;
            ctl_msg_out        <= ctl_msg_in ^ 256'h5A;
         end
      end
   end

   int inv_pulses = 0;
   int exp_pulses = 0;
   always @(posedge clk) begin
      if (ctl_reset_inverter) inv_pulses <= inv_pulses + 1;
      if (ctl_reset_mod_exp)  exp_pulses <= exp_pulses + 1;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct packed {
      logic [MW-1:0] msg;
      logic          err;
   } res_t;
   res_t exp_q[$];
   res_t mon_e;

   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", MW'(res_valid), '0);
         end else begin
            mon_e = exp_q.pop_front();
            check("res_msg", res_msg, mon_e.msg);
            check("res_error", MW'(res_error), MW'(mon_e.err));
         end
      end
   end

   int          inv0;
   int          exp0;
   logic [15:0] jd0;

   task automatic issue(input logic [W-1:0] p, input logic [W-1:0] q, input logic dir,
                        input logic [MW-1:0] msg, input logic [MW-1:0] exp_msg,
                        input logic exp_err, input logic hit, input logic push);
      int k;
      inv0 = inv_pulses;
      exp0 = exp_pulses;
      jd0  = jobs_done;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!job_ready && k < 300);
      if (!job_ready) begin
         check("job_ready_wait", MW'(job_ready), MW'(1));
         return;
      end
      job_p               = p;
      job_q               = q;
      job_encrypt_decrypt = dir;
      job_msg             = msg;
      job_valid           = 1'b1;
      if (push) exp_q.push_back('{msg: exp_msg, err: exp_err});
      @(posedge clk);
      #1 job_valid = 1'b0;
      @(negedge clk);
      check(hit ? "hit_pulse" : "miss_pulse", MW'({ctl_reset_inverter, ctl_reset_mod_exp}),
            hit ? MW'(2'b01) : MW'(2'b10));
   endtask

   task automatic finish_job(input string name, input int exp_inv);
      int k;
      k = 0;
      while (jobs_done == jd0 && k < 600) begin
         @(negedge clk);
         k++;
      end
      check({name, "_jobs_done"}, MW'(jobs_done), MW'(jd0 + 16'd1));
      check({name, "_inv_pulses"}, MW'(inv_pulses - inv0), MW'(exp_inv));
      check({name, "_exp_pulses"}, MW'(exp_pulses - exp0), MW'(1));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MW-1:0] hold_msg;
      logic          stable;
      int            k;

      repeat (3) @(negedge clk);
      check("rst_job_ready", MW'(job_ready), MW'(1));
      check("rst_outputs", MW'({ctl_reset_inverter, ctl_reset_mod_exp, res_valid, res_error}), '0);
      check("rst_jobs_done", MW'(jobs_done), '0);
      @(posedge clk);
      #1 reset = 1'b0;

      // 1: fresh key
      issue(P1, Q1, 1'b0, 256'h9d, 256'hc7, 1'b0, 1'b0, 1'b1);
      check("s1_ctl_p", MW'(ctl_p), MW'(P1));
      check("s1_ctl_msg_in", ctl_msg_in, 256'h9d);
      finish_job("s1", 1);

      // 2: same key skips the inverter
      issue(P1, Q1, 1'b1, 256'h2dc600, 256'h2dc65a, 1'b0, 1'b1, 1'b1);
      check("s2_ctl_dir", MW'(ctl_encrypt_decrypt), MW'(1));
      finish_job("s2", 0);

      // 3: swapped factors miss the cache
      issue(Q1, P1, 1'b0, 256'h1234, 256'h126e, 1'b0, 1'b0, 1'b1);
      finish_job("s3", 1);

      // 4: no finish -> timeout, then same key re-runs the inverter
      @(posedge clk);
      #1 model_en = 1'b0;
      issue(Q1, P1, 1'b0, 256'h77, 256'h0, 1'b1, 1'b1, 1'b1);
      finish_job("s4_timeout", 0);
      @(posedge clk);
      #1 model_en = 1'b1;
      issue(Q1, P1, 1'b0, 256'hff, 256'ha5, 1'b0, 1'b0, 1'b1);
      finish_job("s4_rerun", 1);

      // 5: consumer stalls the result
      @(posedge clk);
      #1 res_ready = 1'b0;
      issue(Q1, P1, 1'b0, 256'h100, 256'h15a, 1'b0, 1'b1, 1'b1);
      k = 0;
      while (!res_valid && k < 300) begin
         @(negedge clk);
         k++;
      end
      hold_msg = res_msg;
      stable   = res_valid;
      repeat (30) begin
         @(negedge clk);
         if (!res_valid || res_msg !== hold_msg || job_ready || jobs_done !== jd0) stable = 1'b0;
      end
      check("s5_hold_stable", MW'(stable), MW'(1));
      check("s5_held_msg", hold_msg, 256'h15a);
      @(posedge clk);
      #1 res_ready = 1'b1;
      finish_job("s5", 0);

      // 6: reset during EXP_WAIT abandons the job
      issue(Q1, P1, 1'b0, 256'h42, 256'h0, 1'b0, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("s6_rst_ctl", MW'({job_ready, ctl_reset_inverter, ctl_reset_mod_exp,
                               res_valid, res_error, ctl_encrypt_decrypt}), MW'(6'b100000));
      check("s6_rst_data", MW'(ctl_p) | MW'(ctl_q) | ctl_msg_in | res_msg, '0);
      check("s6_rst_jobs_done", MW'(jobs_done), '0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("s6_job_ready", MW'(job_ready), MW'(1));
      issue(Q1, P1, 1'b0, 256'h9d, 256'hc7, 1'b0, 1'b0, 1'b1);
      finish_job("s6", 1);

      repeat (3) @(negedge clk);
      check("queue_empty", MW'(exp_q.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
